gcode_command_fifo: RTL and testbench

First-word-fall-through command queue sitting directly upstream of the controller interface stage. It buffers decoded G-code commands (opcode plus 14-bit X/Y operands) arriving from the command parser and presents the head entry to the controller interface with a `memory_ready` flag. It pops the head entry only when the downstream stage actually consumes it: `memory_ready & controller_ready & ~block`. Commands with invalid opcodes are rejected at the write side and flagged.

---
 rtl/gcode_command_fifo.sv | 121 ++++++++++++
 tb/tb_gcode_command_fifo.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/gcode_command_fifo.sv
// gcode_command_fifo: first-word-fall-through queue of decoded G-code commands
// between the command parser and the controller interface stage. Entries are
// {cmd[3:0], x[13:0], y[13:0]}. Invalid opcodes are rejected at the write side
// and latched in a sticky bad_cmd flag; popping an M2 latches program_end.
module gcode_command_fifo #(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [3:0]    wr_cmd,
  input  logic [13:0]   wr_x,
  input  logic [13:0]   wr_y,
  input  logic          flush,
  input  logic          controller_ready,
  input  logic          block,
  output logic [3:0]    cmd_out,
  output logic [13:0]   x_out,
  output logic [13:0]   y_out,
  output logic          memory_ready,
  output logic [CW-1:0] count,
  output logic          bad_cmd,
  output logic          program_end
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] OP_M2  = 4'd6;
  localparam logic [3:0] OP_MAX = 4'd8;

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_bad_cmd;
  logic          r_program_end;

  logic          w_full;
  logic          w_empty;
  logic          w_cmd_ok;
  logic          w_push;
  logic          w_reject;
  logic          w_pop;
  logic [31:0]   w_head;

  // Full/empty come from the registered count only, so neither handshake
  // output has a combinational path from downstream inputs.
  assign w_full   = (r_count == CW'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_cmd_ok = (wr_cmd <= OP_MAX);

  // Flush wins over any push, reject or pop in the same cycle.
  assign w_push   = wr_valid & ~w_full & w_cmd_ok  & ~flush;
  assign w_reject = wr_valid & ~w_full & ~w_cmd_ok & ~flush;
  assign w_pop    = ~w_empty & controller_ready & ~block & ~flush;

  assign w_head   = r_mem[r_rd_ptr];

  // Head is forced to zero while empty so outputs are defined during and
  // right after reset without having to reset the storage array.
  assign cmd_out      = w_empty ? 4'd0  : w_head[31:28];
  assign x_out        = w_empty ? 14'd0 : w_head[27:14];
  assign y_out        = w_empty ? 14'd0 : w_head[13:0];
  assign memory_ready = ~w_empty;
  assign wr_ready     = ~w_full;
  assign count        = r_count;
  assign bad_cmd      = r_bad_cmd;
  assign program_end  = r_program_end;

  // Storage write; entries are only meaningful below count, so no reset needed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {wr_cmd, wr_x, wr_y};
    end
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH (power of two).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // Sticky status flags, cleared only by reset or flush.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bad_cmd     <= 1'b0;
      r_program_end <= 1'b0;
    end else if (flush) begin
      r_bad_cmd     <= 1'b0;
      r_program_end <= 1'b0;
    end else begin
      if (w_reject) begin
        r_bad_cmd <= 1'b1;
      end
      if (w_pop && (w_head[31:28] == OP_M2)) begin
        r_program_end <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gcode_command_fifo.sv
// Self-checking bench for gcode_command_fifo: a queue model predicts pushes,
// pops and flags; popped entries are compared against the DUT head.
module tb_gcode_command_fifo;

  localparam int DEPTH = 16;
  localparam int CW    = 5;

  logic          clk;
  logic          reset_n;
  logic          wr_valid;
  logic          wr_ready;
  logic [3:0]    wr_cmd;
  logic [13:0]   wr_x;
  logic [13:0]   wr_y;
  logic          flush;
  logic          controller_ready;
  logic          block;
  logic [3:0]    cmd_out;
  logic [13:0]   x_out;
  logic [13:0]   y_out;
  logic          memory_ready;
  logic [CW-1:0] count;
  logic          bad_cmd;
  logic          program_end;

  gcode_command_fifo #(.DEPTH(DEPTH)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .wr_valid         (wr_valid),
    .wr_ready         (wr_ready),
    .wr_cmd           (wr_cmd),
    .wr_x             (wr_x),
    .wr_y             (wr_y),
    .flush            (flush),
    .controller_ready (controller_ready),
    .block            (block),
    .cmd_out          (cmd_out),
    .x_out            (x_out),
    .y_out            (y_out),
    .memory_ready     (memory_ready),
    .count            (count),
    .bad_cmd          (bad_cmd),
    .program_end      (program_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] sb[$];
  logic        m_bad = 1'b0;
  logic        m_pe  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    wr_valid = 1'b0; wr_cmd = 4'd0; wr_x = 14'd0; wr_y = 14'd0;
    flush = 1'b0; controller_ready = 1'b0; block = 1'b0;
  endtask

  // Called at a negedge: drive inputs, predict, check popped head, advance one clock.
  task automatic cyc(input logic v, input logic [3:0] c, input logic [13:0] x,
                     input logic [13:0] y, input logic cr, input logic blk,
                     input logic fl);
    logic push, pop, rej;
    wr_valid = v; wr_cmd = c; wr_x = x; wr_y = y;
    controller_ready = cr; block = blk; flush = fl;
    push = v && (sb.size() < DEPTH) && (c <= 4'd8) && !fl;
    rej  = v && (sb.size() < DEPTH) && (c > 4'd8) && !fl;
    pop  = (sb.size() != 0) && cr && !blk && !fl;
    #1;
    chk("memory_ready", 32'(memory_ready), 32'(sb.size() != 0));
    chk("wr_ready", 32'(wr_ready), 32'(sb.size() < DEPTH));
    if (pop) begin
      chk("head_cmd", 32'(cmd_out), 32'(sb[0][31:28]));
      chk("head_x", 32'(x_out), 32'(sb[0][27:14]));
      chk("head_y", 32'(y_out), 32'(sb[0][13:0]));
    end
    @(posedge clk);
    if (fl) begin
      sb.delete();
      m_bad = 1'b0;
      m_pe  = 1'b0;
    end else begin
      if (pop) begin
        if (sb[0][31:28] == 4'd6) m_pe = 1'b1;
        void'(sb.pop_front());
      end
      if (push) sb.push_back({c, x, y});
      if (rej) m_bad = 1'b1;
    end
    @(negedge clk);
    idle();
    chk("count", 32'(count), 32'(sb.size()));
    chk("bad_cmd", 32'(bad_cmd), 32'(m_bad));
    chk("program_end", 32'(program_end), 32'(m_pe));
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    @(negedge clk);
    chk("rst_memory_ready", 32'(memory_ready), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_cmd_out", 32'(cmd_out), 32'd0);
    chk("rst_x_out", 32'(x_out), 32'd0);
    chk("rst_y_out", 32'(y_out), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single push G01 100/200, then pop.
    cyc(1'b1, 4'd1, 14'd100, 14'd200, 1'b0, 1'b0, 1'b0);
    chk("first_cmd", 32'(cmd_out), 32'd1);
    chk("first_x", 32'(x_out), 32'd100);
    chk("first_y", 32'(y_out), 32'd200);
    chk("first_count", 32'(count), 32'd1);
    cyc(1'b0, 4'd0, 14'd0, 14'd0, 1'b1, 1'b0, 1'b0);
    chk("after_pop_mr", 32'(memory_ready), 32'd0);

    // Fill to full, try a 17th, then drain one per cycle across the wrap.
    for (int i = 0; i < DEPTH; i++)
      cyc(1'b1, 4'd1, 14'(i), 14'(i + 1), 1'b0, 1'b0, 1'b0);
    chk("full_count", 32'(count), 32'd16);
    chk("full_wr_ready", 32'(wr_ready), 32'd0);
    cyc(1'b1, 4'd0, 14'd99, 14'd99, 1'b0, 1'b0, 1'b0);
    chk("ignored_17th", 32'(count), 32'd16);
    for (int i = 0; i < DEPTH; i++)
      cyc(1'b0, 4'd0, 14'd0, 14'd0, 1'b1, 1'b0, 1'b0);
    chk("drained", 32'(count), 32'd0);

    // Block holds pops while pushes continue; then steady push+pop.
    for (int i = 0; i < 5; i++)
      cyc(1'b1, 4'd4, 14'(20 + i), 14'(i), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 4'd5, 14'd25, 14'd5, 1'b1, 1'b1, 1'b0);
    chk("block_count", 32'(count), 32'd6);
    for (int i = 0; i < 8; i++)
      cyc(1'b1, 4'd0, 14'(30 + i), 14'(i), 1'b1, 1'b0, 1'b0);
    chk("steady_count", 32'(count), 32'd6);

    // Invalid opcode is rejected and sticky; a following G20 is stored.
    cyc(1'b1, 4'd12, 14'd1, 14'd1, 1'b0, 1'b0, 1'b0);
    chk("bad_count", 32'(count), 32'd6);
    chk("bad_set", 32'(bad_cmd), 32'd1);
    cyc(1'b1, 4'd2, 14'd42, 14'd43, 1'b0, 1'b0, 1'b0);
    chk("g20_count", 32'(count), 32'd7);
    chk("bad_sticky", 32'(bad_cmd), 32'd1);

    // Drain, then push M2 and pop it.
    for (int i = 0; i < 7; i++)
      cyc(1'b0, 4'd0, 14'd0, 14'd0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 4'd6, 14'd5, 14'd6, 1'b0, 1'b0, 1'b0);
    chk("pe_before", 32'(program_end), 32'd0);
    cyc(1'b0, 4'd0, 14'd0, 14'd0, 1'b1, 1'b0, 1'b0);
    chk("pe_after", 32'(program_end), 32'd1);

    // Flush with 3 queued and a push+pop asserted.
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 4'd7, 14'(50 + i), 14'(i), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 4'd1, 14'd60, 14'd61, 1'b1, 1'b0, 1'b1);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_mr", 32'(memory_ready), 32'd0);
    chk("flush_bad", 32'(bad_cmd), 32'd0);
    chk("flush_pe", 32'(program_end), 32'd0);

    // Async reset mid-stream with 7 entries.
    for (int i = 0; i < 7; i++)
      cyc(1'b1, 4'd3, 14'(70 + i), 14'(i), 1'b0, 1'b0, 1'b0);
    chk("pre_reset_count", 32'(count), 32'd7);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_mr", 32'(memory_ready), 32'd0);
    chk("arst_wr_ready", 32'(wr_ready), 32'd1);
    chk("arst_x_out", 32'(x_out), 32'd0);
    sb.delete();
    m_bad = 1'b0;
    m_pe  = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    cyc(1'b1, 4'd5, 14'd777, 14'd888, 1'b0, 1'b0, 1'b0);
    chk("post_rst_cmd", 32'(cmd_out), 32'd5);
    chk("post_rst_x", 32'(x_out), 32'd777);
    cyc(1'b0, 4'd0, 14'd0, 14'd0, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
